// File: rtl/mc_control_fsm.sv
// Multicycle ARM control unit: instruction decode, state sequencing,
// NZCV flags and condition-gated datapath enables.
// Ports: clk, reset (async, active-low), Instr[31:12] as Instr[19:0],
//   ALUFlags {N,Z,C,V}; outputs are the datapath enables and mux selects.
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
  } state_e;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign funct = Instr[13:8];
  assign rd    = Instr[3:0];
  assign cmd   = funct[4:1];

  // Rn only matters to the datapath.
  logic unused_rn;
  assign unused_rn = ^Instr[7:4];

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  logic n, z, c, v;
  assign {n, z, c, v} = flags_q;

  logic cond_ex;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic next_pc, branch, reg_w, mem_w, alu_op;

  always_comb begin
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECR: alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  logic is_add, is_sub, is_and, is_orr, is_cmp;
  assign is_add = (cmd == 4'b0100);
  assign is_sub = (cmd == 4'b0010);
  assign is_and = (cmd == 4'b0000);
  assign is_orr = (cmd == 4'b1100);
  assign is_cmp = (cmd == 4'b1010);

  // NoWrite is decoded from funct in ALUWB too, where alu_op is low,
  // so it keys off the data-processing op rather than alu_op.
  logic no_write;
  assign no_write = (op == 2'b00) &
                    ~(is_add | is_sub | is_and | is_orr);

  logic [1:0] flag_w;
  assign flag_w[1] = alu_op & funct[0] &
                     (is_add | is_sub | is_and | is_orr | is_cmp);
  assign flag_w[0] = alu_op & funct[0] &
                     (is_add | is_sub | is_cmp);

  always_comb begin
    ALUControl = 2'b00;
    if (alu_op) begin
      unique case (1'b1)
        is_sub, is_cmp: ALUControl = 2'b01;
        is_and:         ALUControl = 2'b10;
        is_orr:         ALUControl = 2'b11;
        default:        ALUControl = 2'b00;
      endcase
    end
  end

  logic pcs;
  assign pcs = ((rd == 4'hF) & reg_w) | branch;

  assign PCWrite  = next_pc | (pcs & cond_ex_q);
  assign RegWrite = reg_w & cond_ex_q & ~no_write;
  assign MemWrite = mem_w & cond_ex_q;
  assign ImmSrc   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:  state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECR,
      EXECI:   state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // Condition is latched at DECODE so an EXEC flag update
  // cannot alter the gating of its own writeback.
  always_comb begin
    cond_ex_d = cond_ex_q;
    if (state_q == DECODE) cond_ex_d = cond_ex;
  end

  always_comb begin
    flags_d = flags_q;
    if (cond_ex_q) begin
      if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

endmodule
